// File: rtl/calculation_sub.sv
// Multi-cycle unsigned subtractor: resolves a-b and b-a CHUNK bits per cycle with ripple-borrow
// chains, then reports a-b, |a-b| and the borrow through a valid/ready handshake.
module calculation_sub #(
    parameter int W     = 32,
    parameter int CHUNK = 8
) (
    input  logic         sub_clk,
    input  logic         sub_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic [W-1:0] abs_diff,
    output logic         borrow,
    output logic         busy
);

    localparam int N     = W / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (W % CHUNK != 0) begin : g_width_check
            $error("calculation_sub: W must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   chunk_cnt;
    logic [W-1:0]       op_a;
    logic [W-1:0]       op_b;
    logic [W-1:0]       res_ab;
    logic [W-1:0]       res_ba;
    logic               bor_ab;
    logic               bor_ba;

    logic [CHUNK:0]     step_ab;
    logic [CHUNK:0]     step_ba;
    logic [W-1:0]       next_ab;
    logic [W-1:0]       next_ba;

    // One chunk of a ripple-borrow chain; returns {borrow_out, difference}.
    function automatic logic [CHUNK:0] sub_chunk(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             bin);
        logic [CHUNK-1:0] d;
        logic             bi;
        bi = bin;
        d  = '0;
        for (int i = 0; i < CHUNK; i++) begin
            d[i] = x[i] ^ y[i] ^ bi;
            bi   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bi);
        end
        return {bi, d};
    endfunction

    // Operands shift right each RUN edge, so the active chunk always sits in the low bits;
    // results fill in from the top and are complete after N shifts.
    assign step_ab = sub_chunk(op_a[CHUNK-1:0], op_b[CHUNK-1:0], bor_ab);
    assign step_ba = sub_chunk(op_b[CHUNK-1:0], op_a[CHUNK-1:0], bor_ba);
    assign next_ab = (res_ab >> CHUNK) | (W'(step_ab[CHUNK-1:0]) << (W - CHUNK));
    assign next_ba = (res_ba >> CHUNK) | (W'(step_ba[CHUNK-1:0]) << (W - CHUNK));

    always_ff @(posedge sub_clk or posedge sub_rst) begin
        if (sub_rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            diff      <= '0;
            abs_diff  <= '0;
            borrow    <= 1'b0;
            chunk_cnt <= '0;
            op_a      <= '0;
            op_b      <= '0;
            res_ab    <= '0;
            res_ba    <= '0;
            bor_ab    <= 1'b0;
            bor_ba    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op_a      <= a;
                        op_b      <= b;
                        res_ab    <= '0;
                        res_ba    <= '0;
                        bor_ab    <= 1'b0;
                        bor_ba    <= 1'b0;
                        chunk_cnt <= '0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    op_a      <= op_a >> CHUNK;
                    op_b      <= op_b >> CHUNK;
                    res_ab    <= next_ab;
                    res_ba    <= next_ba;
                    bor_ab    <= step_ab[CHUNK];
                    bor_ba    <= step_ba[CHUNK];
                    chunk_cnt <= chunk_cnt + CNT_W'(1);
                    // Final chunk: publish straight from the chain so latency stays at N edges.
                    if (chunk_cnt == CNT_W'(N - 1)) begin
                        diff      <= next_ab;
                        borrow    <= step_ab[CHUNK];
                        abs_diff  <= step_ab[CHUNK] ? next_ba : next_ab;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calculation_sub.sv
// Bench for calculation_sub: directed corner cases plus randomized pairs with output stalls,
// checked against a plain-arithmetic reference of unsigned subtraction.
module tb_calculation_sub;

    localparam int W     = 32;
    localparam int CHUNK = 8;
    localparam int N     = W / CHUNK;

    logic          sub_clk;
    logic          sub_rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  diff;
    logic [W-1:0]  abs_diff;
    logic          borrow;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    calculation_sub #(.W(W), .CHUNK(CHUNK)) dut (
        .sub_clk   (sub_clk),
        .sub_rst   (sub_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .abs_diff  (abs_diff),
        .borrow    (borrow),
        .busy      (busy)
    );

    initial sub_clk = 1'b0;
    always #5 sub_clk = ~sub_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sub_clk);
        #1;
    endtask

    // Presents one pair, then counts edges from the accept edge until out_valid appears.
    task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        tick();
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    // Checks a presented result, holds it for `stall` cycles, then completes the handshake.
    task automatic checkOutput(input string tag, input logic [W-1:0] e_diff,
                               input logic [W-1:0] e_abs, input logic e_b, input int stall);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_diff"},      64'(diff),      64'(e_diff));
        check({tag, "_abs_diff"},  64'(abs_diff),  64'(e_abs));
        check({tag, "_borrow"},    64'(borrow),    64'(e_b));
        check({tag, "_busy"},      64'(busy),      64'd1);
        for (int i = 0; i < stall; i++) begin
            tick();
            a = $urandom;
            b = $urandom;
        end
        if (stall > 0) begin
            check({tag, "_stall_valid"}, {out_valid, in_ready}, {1'b1, 1'b0});
            check({tag, "_stall_hold"},  {diff, abs_diff[30:0], borrow}, {e_diff, e_abs[30:0], e_b});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_after_hs"}, {out_valid, in_ready, busy}, {1'b0, 1'b1, 1'b0});
        check({tag, "_kept_diff"}, 64'(diff), 64'(e_diff));
    endtask

    task automatic run_pair(input logic [W-1:0] va, input logic [W-1:0] vb,
                            input int stall, input string tag);
        logic [W-1:0] e_diff;
        logic [W-1:0] e_abs;
        logic         e_b;
        int           lat;
        e_diff = va - vb;
        e_b    = (va < vb);
        e_abs  = e_b ? (vb - va) : (va - vb);
        applyStimulus(va, vb, lat);
        check({tag, "_latency"}, 64'(lat), 64'(N));
        checkOutput(tag, e_diff, e_abs, e_b, stall);
    endtask

    initial begin
        int          lat;
        int          seen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        sub_rst   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        $display("[TB] reset");
        repeat (3) tick();
        check("reset_ctrl", {in_ready, out_valid, busy, borrow}, {1'b1, 1'b0, 1'b0, 1'b0});
        check("reset_diff", 64'(diff), 64'd0);
        check("reset_abs",  64'(abs_diff), 64'd0);
        sub_rst = 1'b0;
        tick();

        $display("[TB] directed pairs");
        run_pair(32'h0000_0064, 32'h0000_001E, 0, "t1");
        run_pair(32'h0000_001E, 32'h0000_0064, 1, "t2");
        run_pair(32'h0000_0000, 32'hFFFF_FFFF, 0, "t3_zero_max");
        run_pair(32'h8000_0000, 32'h8000_0000, 0, "t3_equal");
        run_pair(32'h0100_0000, 32'h0000_0001, 2, "t3_ripple");
        run_pair(32'hFFFF_FFFF, 32'h0000_0000, 0, "t3_max_zero");

        $display("[TB] long stall with ignored input");
        applyStimulus(32'h1234_5678, 32'h0BAD_F00D, lat);
        check("t4_latency", 64'(lat), 64'(N));
        in_valid = 1'b1;
        a        = 32'hDEAD_BEEF;
        b        = 32'h0000_0001;
        for (int i = 0; i < 10; i++) tick();
        in_valid = 1'b0;
        checkOutput("t4", 32'h1234_5678 - 32'h0BAD_F00D, 32'h1234_5678 - 32'h0BAD_F00D, 1'b0, 0);
        run_pair(32'h0000_0005, 32'h0000_0007, 0, "t4_next");

        $display("[TB] reset during RUN");
        in_valid = 1'b1;
        a        = 32'h0000_0010;
        b        = 32'h0000_0003;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        sub_rst = 1'b1;
        #1;
        check("t5_rst_ctrl", {out_valid, busy, in_ready, borrow}, {1'b0, 1'b0, 1'b1, 1'b0});
        check("t5_rst_diff", {diff, abs_diff}, 64'd0);
        tick();
        sub_rst = 1'b0;
        seen    = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("t5_no_out_valid", 64'(seen), 64'd0);
        run_pair(32'hCAFE_0000, 32'h0000_BABE, 1, "t5_post");

        $display("[TB] random pairs");
        for (int k = 0; k < 4000; k++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = ra;
                1: rb = ra + 32'(1);
                2: ra = ra & 32'h0000_00FF;
                default: ;
            endcase
            run_pair(ra, rb, $urandom_range(0, 3), "rand");
            if (n_fail >= 20) break;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
